// File: rtl/fegp_pkg.sv
// Shared types for the FEG 8-bit control path: opcodes, sequencer states, instruction fields.
// No logic; imported by the sequencer and its decoder.
// Instruction layout: [8:6] op, [5:4] rd, [3:2] rs/immed, [0] mode; BR offset is [5:0].
package fegp_pkg;

   typedef enum logic [2:0] {
      OP_LDR    = 3'b000,
      OP_STR    = 3'b001,
      OP_MOVADD = 3'b010,
      OP_XOR    = 3'b011,
      OP_AND    = 3'b100,
      OP_SHIFT  = 3'b101,
      OP_CMP    = 3'b110,
      OP_BR     = 3'b111
   } opcode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_HALT
   } seq_state_t;

   localparam int IR_W     = 9;
   localparam int OP_HI    = 8;
   localparam int OP_LO    = 6;
   localparam int RD_HI    = 5;
   localparam int RD_LO    = 4;
   localparam int RS_HI    = 3;
   localparam int RS_LO    = 2;
   localparam int MODE_BIT = 0;
   localparam int OFF_HI   = 5;
   localparam int OFF_LO   = 0;
   localparam int OFF_W    = OFF_HI - OFF_LO + 1;

   function automatic logic is_alu_op(input opcode_t op);
      return (op == OP_MOVADD) || (op == OP_XOR) || (op == OP_AND) || (op == OP_SHIFT);
   endfunction

endpackage

// File: rtl/fegp_instr_decode.sv
// Instruction decoder: splits ir into ALU/register controls and the sign-extended branch offset.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow ir directly.
module fegp_instr_decode
   import fegp_pkg::*;
#(
   parameter int PC_W = 10
) (
   input  logic [IR_W-1:0] ir,
   output opcode_t         op,
   output logic [2:0]      alu_cmd,
   output logic [1:0]      immed,
   output logic            direct,
   output logic            moveControl,
   output logic [1:0]      rd_sel,
   output logic [1:0]      rs_sel,
   output logic            writes_reg,
   output logic            br_halt,
   output logic [PC_W-1:0] br_off
);

   assign op          = opcode_t'(ir[OP_HI:OP_LO]);
   assign alu_cmd     = ir[OP_HI:OP_LO];
   assign immed       = ir[RS_HI:RS_LO];
   assign direct      = ir[MODE_BIT];
   assign moveControl = ir[MODE_BIT];
   assign rd_sel      = ir[RD_HI:RD_LO];
   assign rs_sel      = ir[RS_HI:RS_LO];
   assign writes_reg  = is_alu_op(op);

   // A zero branch offset is the halt encoding, not a self-loop.
   assign br_halt = (ir[OFF_HI:OFF_LO] == '0);
   assign br_off  = {{(PC_W-OFF_W){ir[OFF_HI]}}, ir[OFF_HI:OFF_LO]};

endmodule

// File: rtl/fegp_ctrl_seq.sv
// FEG control sequencer: fetch/decode/exec (+MEM for LDR/STR); FEGP_MEM_TIMEOUT_EN adds a MEM watchdog.
// Latency: 3 cycles per ALU/CMP/BR instruction, 3 + wait cycles for LDR/STR.
// Backpressure: mem_req held until mem_ack; start ignored outside IDLE/HALT.
module fegp_ctrl_seq
   import fegp_pkg::*;
#(
   parameter int PC_W    = 10
`ifdef FEGP_MEM_TIMEOUT_EN
   , parameter int TIMEOUT = 16
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [PC_W-1:0] imem_addr,
   input  logic [IR_W-1:0] imem_data,
   output logic [2:0]      alu_cmd,
   output logic [1:0]      immed,
   output logic            direct,
   output logic            moveControl,
   output logic [1:0]      rd_sel,
   output logic [1:0]      rs_sel,
   output logic            reg_we,
   input  logic            br_logic,
   output logic            mem_req,
   output logic            mem_we,
   input  logic            mem_ack,
   output logic            done,
   output logic            err
);

   seq_state_t      state;
   logic [PC_W-1:0] pc;
   logic [IR_W-1:0] ir;
   logic            flag;

   opcode_t         op;
   logic            writes_reg;
   logic            br_halt;
   logic [PC_W-1:0] br_off;
   logic            timeout_hit;

   fegp_instr_decode #(.PC_W(PC_W)) u_decode (
      .ir          (ir),
      .op          (op),
      .alu_cmd     (alu_cmd),
      .immed       (immed),
      .direct      (direct),
      .moveControl (moveControl),
      .rd_sel      (rd_sel),
      .rs_sel      (rs_sel),
      .writes_reg  (writes_reg),
      .br_halt     (br_halt),
      .br_off      (br_off)
   );

   assign imem_addr = pc;

   // LDR writeback must coincide with the ack cycle, so reg_we is decoded rather than registered.
   assign reg_we = ((state == ST_EXEC) && writes_reg) ||
                   ((state == ST_MEM) && (op == OP_LDR) && mem_ack);

`ifdef FEGP_MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   // wait_cnt holds (MEM cycle number - 1); an ack in the last allowed cycle still wins.
   assign timeout_hit = (state == ST_MEM) && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
   assign err         = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == ST_MEM) wait_cnt <= wait_cnt + CNT_W'(1);
         else                 wait_cnt <= '0;
         if (timeout_hit)                     err_q <= 1'b1;
         else if ((state == ST_HALT) && start) err_q <= 1'b0;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         pc      <= '0;
         ir      <= '0;
         flag    <= 1'b0;
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  pc    <= '0;
                  state <= ST_FETCH;
               end
            end
            ST_FETCH:  state <= ST_DECODE;
            ST_DECODE: begin
               ir    <= imem_data;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               case (op)
                  OP_LDR, OP_STR: begin
                     mem_req <= 1'b1;
                     mem_we  <= (op == OP_STR);
                     state   <= ST_MEM;
                  end
                  OP_CMP: begin
                     flag  <= br_logic;
                     pc    <= pc + PC_W'(1);
                     state <= ST_FETCH;
                  end
                  OP_BR: begin
                     if (br_halt) begin
                        done  <= 1'b1;
                        state <= ST_HALT;
                     end else begin
                        state <= ST_FETCH;
                        if (flag) begin
                           pc   <= pc + br_off;
                           flag <= 1'b0;
                        end else begin
                           pc <= pc + PC_W'(1);
                        end
                     end
                  end
                  default: begin
                     pc    <= pc + PC_W'(1);
                     state <= ST_FETCH;
                  end
               endcase
            end
            ST_MEM: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  pc      <= pc + PC_W'(1);
                  state   <= ST_FETCH;
               end else if (timeout_hit) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_HALT;
               end
            end
            ST_HALT: begin
               if (start) begin
                  pc    <= '0;
                  flag  <= 1'b0;
                  done  <= 1'b0;
                  state <= ST_FETCH;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fegp_ctrl_seq.sv
// Bench for fegp_ctrl_seq: ROM model, per-scenario tasks, queue of expected fetch/writeback values.
// Define FEGP_MEM_TIMEOUT_EN for both bench and RTL to exercise the MEM watchdog.
module tb_fegp_ctrl_seq;

   localparam int PC_W        = 10;
   localparam int TIMEOUT_CYC = 16;

   logic            clk = 1'b0;
   logic            reset, start, br_logic, mem_ack;
   logic [8:0]      imem_data;
   logic [PC_W-1:0] imem_addr;
   logic [2:0]      alu_cmd;
   logic [1:0]      immed, rd_sel, rs_sel;
   logic            direct, moveControl, reg_we, mem_req, mem_we, done, err;

   logic [8:0]  rom [0:(1<<PC_W)-1];
   logic [31:0] exp_q [$];
   logic [31:0] e;
   int          n_tests = 0;
   int          n_fail  = 0;

   fegp_ctrl_seq #(.PC_W(PC_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .alu_cmd     (alu_cmd),
      .immed       (immed),
      .direct      (direct),
      .moveControl (moveControl),
      .rd_sel      (rd_sel),
      .rs_sel      (rs_sel),
      .reg_we      (reg_we),
      .br_logic    (br_logic),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_ack     (mem_ack),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_data <= rom[imem_addr];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rom;
      for (int i = 0; i < (1 << PC_W); i++) rom[i] = 9'h1C0;
   endtask

   task automatic do_reset;
      reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
      tick; tick;
      reset = 1'b0;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; mem_ack = 1'b0; br_logic = 1'b0;
      tick; tick;
      n_tests++;
      if ({alu_cmd, immed, direct, moveControl, rd_sel, rs_sel} !== 11'd0) begin
         n_fail++; $display("FAIL reset_alu_fields got=%h want=000", {alu_cmd, immed, direct, moveControl, rd_sel, rs_sel});
      end
      n_tests++;
      if ({reg_we, mem_req, mem_we, done, err, imem_addr} !== {5'b0, 10'd0}) begin
         n_fail++; $display("FAIL reset_ctrl got=%b addr=%0d want=00000 addr=0", {reg_we, mem_req, mem_we, done, err}, imem_addr);
      end
      reset = 1'b0;
      tick; tick;
      n_tests++;
      if ({done, mem_req, imem_addr} !== {2'b0, 10'd0}) begin
         n_fail++; $display("FAIL idle_hold done=%b req=%b addr=%0d want 0 0 0", done, mem_req, imem_addr);
      end
   endtask

   task automatic test_add;
      fill_rom;
      rom[0] = 9'h09D;
      do_reset;
      pulse_start;
      n_tests++;
      if ({imem_addr, reg_we} !== {10'd0, 1'b0}) begin
         n_fail++; $display("FAIL add_fetch addr=%0d we=%b want addr=0 we=0", imem_addr, reg_we);
      end
      tick; tick;
      n_tests++;
      if ({alu_cmd, immed, direct, moveControl, rd_sel, rs_sel, reg_we} !== {3'b010, 2'b11, 1'b1, 1'b1, 2'b01, 2'b11, 1'b1}) begin
         n_fail++; $display("FAIL add_exec got=%b want=010111101111", {alu_cmd, immed, direct, moveControl, rd_sel, rs_sel, reg_we});
      end
      tick;
      n_tests++;
      if ({imem_addr, reg_we} !== {10'd1, 1'b0}) begin
         n_fail++; $display("FAIL add_next_fetch addr=%0d we=%b want addr=1 we=0", imem_addr, reg_we);
      end
      // start while busy must be ignored
      pulse_start;
      tick;
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL halt_not_early done=%b want=0", done);
      end
      tick;
   endtask

   task automatic test_halt_restart;
      mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if ({done, mem_req, imem_addr} !== {2'b10, 10'd1}) begin
            n_fail++; $display("FAIL halt_hold[%0d] done=%b req=%b addr=%0d want done=1 req=0 addr=1", i, done, mem_req, imem_addr);
         end
         tick;
      end
      mem_ack = 1'b0;
      pulse_start;
      n_tests++;
      if ({done, imem_addr} !== {1'b0, 10'd0}) begin
         n_fail++; $display("FAIL restart done=%b addr=%0d want done=0 addr=0", done, imem_addr);
      end
      tick; tick;
      n_tests++;
      if (reg_we !== 1'b1) begin
         n_fail++; $display("FAIL restart_exec we=%b want=1", reg_we);
      end
   endtask

   task automatic test_cmp_br(input logic taken);
      fill_rom;
      rom[0] = 9'h0C0; rom[1] = 9'h100; rom[2] = 9'h1C4; rom[3] = 9'h140;
      rom[4] = 9'h180; rom[5] = 9'h1FD; rom[6] = 9'h1C0;
      br_logic = taken;
      do_reset;
      for (int a = 0; a < 6; a++) exp_q.push_back(32'(a));
      if (taken) begin
         exp_q.push_back(32'd2); exp_q.push_back(32'd3);
      end else begin
         exp_q.push_back(32'd6);
      end
      pulse_start;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (imem_addr !== e[PC_W-1:0]) begin
            n_fail++; $display("FAIL br_fetch taken=%b addr=%0d want=%0d", taken, imem_addr, e[PC_W-1:0]);
         end
         tick; tick; tick;
      end
      n_tests++;
      if ({done, imem_addr} !== (taken ? {1'b0, 10'd4} : {1'b1, 10'd6})) begin
         n_fail++; $display("FAIL br_end taken=%b done=%b addr=%0d", taken, done, imem_addr);
      end
   endtask

   task automatic test_mem;
      fill_rom;
      rom[0] = 9'h010; rom[1] = 9'h050;
      do_reset;
      pulse_start;
      tick; tick;
      n_tests++;
      if ({mem_req, reg_we} !== 2'b00) begin
         n_fail++; $display("FAIL ldr_exec req=%b we=%b want 0 0", mem_req, reg_we);
      end
      tick;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
      for (int c = 0; c < 4; c++) begin
         mem_ack = (c == 3);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if ({mem_req, mem_we, reg_we, err} !== {2'b10, e[0], 1'b0}) begin
            n_fail++; $display("FAIL ldr_wait[%0d] req/we/rwe/err=%b want=10%b0", c, {mem_req, mem_we, reg_we, err}, e[0]);
         end
         tick;
      end
      mem_ack = 1'b0;
      n_tests++;
      if ({imem_addr, mem_req, reg_we} !== {10'd1, 2'b00}) begin
         n_fail++; $display("FAIL ldr_done addr=%0d req=%b we=%b want addr=1 0 0", imem_addr, mem_req, reg_we);
      end
      tick; tick; tick;
      mem_ack = 1'b1;
      #1;
      n_tests++;
      if ({mem_req, mem_we, reg_we} !== 3'b110) begin
         n_fail++; $display("FAIL str_zero_wait got=%b want=110", {mem_req, mem_we, reg_we});
      end
      tick;
      mem_ack = 1'b0;
      n_tests++;
      if ({imem_addr, mem_req, mem_we} !== {10'd2, 2'b00}) begin
         n_fail++; $display("FAIL str_done addr=%0d req=%b we=%b want addr=2 0 0", imem_addr, mem_req, mem_we);
      end
   endtask

   task automatic test_reset_mem;
      fill_rom;
      rom[0] = 9'h09D; rom[1] = 9'h050;
      do_reset;
      pulse_start;
      repeat (6) tick;
      n_tests++;
      if ({mem_req, imem_addr} !== {1'b1, 10'd1}) begin
         n_fail++; $display("FAIL rst_mem_pre req=%b addr=%0d want req=1 addr=1", mem_req, imem_addr);
      end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      n_tests++;
      if ({mem_req, mem_we, done, imem_addr} !== {3'b000, 10'd0}) begin
         n_fail++; $display("FAIL rst_mem_post req=%b we=%b done=%b addr=%0d want 0 0 0 0", mem_req, mem_we, done, imem_addr);
      end
      mem_ack = 1'b1;
      tick; tick;
      mem_ack = 1'b0;
      n_tests++;
      if ({mem_req, reg_we, imem_addr} !== {2'b00, 10'd0}) begin
         n_fail++; $display("FAIL rst_idle req=%b we=%b addr=%0d want 0 0 0", mem_req, reg_we, imem_addr);
      end
      pulse_start;
      tick; tick;
      n_tests++;
      if ({reg_we, alu_cmd} !== {1'b1, 3'b010}) begin
         n_fail++; $display("FAIL rst_refetch we=%b op=%b want we=1 op=010", reg_we, alu_cmd);
      end
   endtask

`ifdef FEGP_MEM_TIMEOUT_EN
   task automatic test_timeout;
      fill_rom;
      rom[0] = 9'h050;
      do_reset;
      pulse_start;
      tick; tick; tick;
      for (int c = 0; c < TIMEOUT_CYC; c++) begin
         n_tests++;
         if ({mem_req, err, done} !== 3'b100) begin
            n_fail++; $display("FAIL to_wait[%0d] req/err/done=%b want=100", c, {mem_req, err, done});
         end
         tick;
      end
      n_tests++;
      if ({mem_req, err, done, imem_addr} !== {3'b011, 10'd0}) begin
         n_fail++; $display("FAIL to_expire req/err/done=%b addr=%0d want=011 addr=0", {mem_req, err, done}, imem_addr);
      end
      pulse_start;
      n_tests++;
      if ({err, done} !== 2'b00) begin
         n_fail++; $display("FAIL to_restart err/done=%b want=00", {err, done});
      end
      tick; tick; tick;
      repeat (TIMEOUT_CYC - 1) tick;
      mem_ack = 1'b1;
      #1;
      n_tests++;
      if (mem_req !== 1'b1) begin
         n_fail++; $display("FAIL to_last_cycle req=%b want=1", mem_req);
      end
      tick;
      mem_ack = 1'b0;
      n_tests++;
      if ({err, done, imem_addr} !== {2'b00, 10'd1}) begin
         n_fail++; $display("FAIL to_late_ack err/done=%b addr=%0d want=00 addr=1", {err, done}, imem_addr);
      end
   endtask
`else
   task automatic test_no_timeout;
      fill_rom;
      rom[0] = 9'h050;
      do_reset;
      pulse_start;
      tick; tick; tick;
      for (int c = 0; c < 3 * TIMEOUT_CYC; c += 8) begin
         n_tests++;
         if ({mem_req, err, done} !== 3'b100) begin
            n_fail++; $display("FAIL wait_forever[%0d] req/err/done=%b want=100", c, {mem_req, err, done});
         end
         repeat (8) tick;
      end
      mem_ack = 1'b1;
      tick;
      mem_ack = 1'b0;
      n_tests++;
      if ({mem_req, err, imem_addr} !== {2'b00, 10'd1}) begin
         n_fail++; $display("FAIL wait_ack req=%b err=%b addr=%0d want 0 0 1", mem_req, err, imem_addr);
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog timeout n_tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      fill_rom;
      test_reset;
      test_add;
      test_halt_restart;
      test_cmp_br(1'b1);
      test_cmp_br(1'b0);
      test_mem;
      test_reset_mem;
`ifdef FEGP_MEM_TIMEOUT_EN
      test_timeout;
`else
      test_no_timeout;
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
